// File: rtl/pipelined_cla_adder_pkg.sv
// Shared adder definitions: default geometry, result-field index macros and helpers.
// The ADDER_* macros live here so every adder block that imports this package sees the same values.
`ifndef ADDER_DEFS_VH
`define ADDER_DEFS_VH
`define ADDER_SEG_DEFAULT 4
`define ADDER_WIDTH_DEFAULT 32
`define ADDER_CARRY_BIT(W) (W)
`define ADDER_SUM_MSB(W) ((W)-1)
`endif

package pipelined_cla_adder_pkg;

    localparam int unsigned SEG_DEFAULT   = `ADDER_SEG_DEFAULT;
    localparam int unsigned WIDTH_DEFAULT = `ADDER_WIDTH_DEFAULT;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Guarded so an illegal SEG of zero cannot divide by zero during elaboration.
    function automatic int unsigned num_segments(input int unsigned width, input int unsigned seg);
        if (seg == 0) begin
            return 1;
        end
        return width / seg;
    endfunction

    function automatic bit geometry_ok(input int unsigned width, input int unsigned seg);
        if (seg < 1) begin
            return 1'b0;
        end
        return (width % seg) == 0;
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_segment.sv
// Combinational SEG-bit carry-lookahead adder slice with group propagate/generate outputs.
module cla_segment
    import pipelined_cla_adder_pkg::*;
#(
    parameter int unsigned SEG = SEG_DEFAULT
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           pg,
    output logic           gg
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG-1:0] w_gen;
    logic [SEG-1:0] w_prop;
    logic [SEG:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // w_gen[i]: carry out of bit i with ci = 0; w_prop[i]: &p[i:0]. Fully expanded, no ripple.
    always_comb begin
        w_gen  = '0;
        w_prop = '0;
        for (int i = 0; i < SEG; i++) begin
            w_gen[i]  = w_g[i];
            w_prop[i] = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_gen[i]  = w_gen[i] | (w_prop[i] & w_g[j]);
                w_prop[i] = w_prop[i] & w_p[j];
            end
        end
    end

    always_comb begin
        w_c    = '0;
        w_c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            w_c[i+1] = w_gen[i] | (w_prop[i] & ci);
        end
    end

    assign s  = w_p ^ w_c[SEG-1:0];
    assign co = w_c[SEG];
    assign pg = w_prop[SEG-1];
    assign gg = w_gen[SEG-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, one SEG-bit segment per stage, valid/ready with global stall.
// Optional macro ADD_SUB_EN adds a 'sub' input selecting a - b.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned SEG   = SEG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int unsigned NSEG = num_segments(WIDTH, SEG);

    if (!geometry_ok(WIDTH, SEG)) begin : g_bad_geometry
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG and SEG must be at least 1");
    end

    logic             r_v   [NSEG];
    logic [WIDTH-1:0] r_a   [NSEG];
    logic [WIDTH-1:0] r_b   [NSEG];
    logic [WIDTH-1:0] r_s   [NSEG];
    logic             r_c   [NSEG];
    logic             r_ovf;

    logic             w_adv;
    op_e              w_op;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic             w_vin [NSEG];
    logic [WIDTH-1:0] w_ain [NSEG];
    logic [WIDTH-1:0] w_bin [NSEG];
    logic             w_cin [NSEG];
    logic [SEG-1:0]   w_ss  [NSEG];
    logic             w_co  [NSEG];
    logic             w_pg  [NSEG];
    logic             w_gg  [NSEG];
    logic             w_ovf;

`ifdef ADD_SUB_EN
    assign w_op = sub ? OP_SUB : OP_ADD;
`else
    assign w_op = OP_ADD;
`endif

    // Subtraction is a + ~b + 1; the inverted operand travels down the skew registers.
    assign w_b0 = (w_op == OP_SUB) ? ~b : b;
    assign w_c0 = (w_op == OP_SUB) ? 1'b1 : ci;

    assign w_adv    = ~r_v[NSEG-1] | out_ready;
    assign in_ready = w_adv;

    always_comb begin
        w_vin[0] = in_valid;
        w_ain[0] = a;
        w_bin[0] = w_b0;
        w_cin[0] = w_c0;
        for (int k = 1; k < NSEG; k++) begin
            w_vin[k] = r_v[k-1];
            w_ain[k] = r_a[k-1];
            w_bin[k] = r_b[k-1];
            w_cin[k] = r_c[k-1];
        end
    end

    // Each stage always works on the low segment; operands are shifted down as they advance.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        cla_segment #(
            .SEG (SEG)
        ) u_seg (
            .a  (w_ain[k][SEG-1:0]),
            .b  (w_bin[k][SEG-1:0]),
            .ci (w_cin[k]),
            .s  (w_ss[k]),
            .co (w_co[k]),
            .pg (w_pg[k]),
            .gg (w_gg[k])
        );
    end

    // Carry into the MSB is recovered from the MSB's own operands and sum bit.
    assign w_ovf = w_ain[NSEG-1][SEG-1] ^ w_bin[NSEG-1][SEG-1]
                 ^ w_ss[NSEG-1][SEG-1] ^ w_co[NSEG-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            for (int k = 0; k < NSEG; k++) begin
                r_v[k] <= w_vin[k];
                r_a[k] <= w_ain[k] >> SEG;
                r_b[k] <= w_bin[k] >> SEG;
                r_c[k] <= w_gg[k] | (w_pg[k] & w_cin[k]);
                if (k == 0) begin
                    r_s[k] <= '0;
                end else begin
                    r_s[k] <= r_s[k-1];
                end
                r_s[k][k*SEG +: SEG] <= w_ss[k];
            end
            r_ovf <= w_vin[NSEG-1] & w_ovf;
        end
    end

    assign out_valid                         = r_v[NSEG-1];
    assign sum[`ADDER_CARRY_BIT(WIDTH)]      = r_c[NSEG-1];
    assign sum[`ADDER_SUM_MSB(WIDTH):0]      = r_s[NSEG-1];
    assign ovf                               = r_ovf;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed vectors, backpressure stream, mid-flight reset.
// Build with ADD_SUB_EN defined to exercise the subtract path as well.
module tb_pipelined_cla_adder;

    localparam int W    = 32;
    localparam int NSEG = 8;

    typedef struct {
        logic [W:0] sum;
        logic       ovf;
        int         acc;
        bit         chkLat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W:0]   sum;
    logic         ovf;
`ifdef ADD_SUB_EN
    logic         sub = 1'b0;
`endif

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         popCount = 0;
    logic [W:0] tbExpSum = '0;
    logic       tbExpOvf = 1'b0;
    bit         tbChkLat = 1'b0;

    pipelined_cla_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W+1:0] modelAdd(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        return {(x[W-1] == y[W-1]) && (s[W-1] != x[W-1]), s};
    endfunction

    // Monitor: compares the presented result every cycle, pops on transfer, records accepted inputs.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected result: got sum 0x%0h expected no output", sum);
                end else begin
                    checkOutput("sum", 64'(sum), 64'(sbq[0].sum));
                    checkOutput("ovf", 64'(ovf), 64'(sbq[0].ovf));
                    if (out_ready) begin
                        if (sbq[0].chkLat) begin
                            checkOutput("latency", 64'(cycle - sbq[0].acc), 64'(NSEG));
                        end
                        void'(sbq.pop_front());
                        popCount++;
                    end
                end
            end else begin
                checkOutput("ovf idle", 64'(ovf), 64'd0);
            end
            if (in_valid && in_ready) begin
                sbq.push_back('{tbExpSum, tbExpOvf, cycle, tbChkLat});
            end
        end
    end

    // Drives one operation at posedge+1 and holds it until accepted; returns at posedge+1.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci,
                                 input logic [W:0] es, input logic eo, input bit lat);
        bit accepted;
        accepted = 1'b0;
        a        = ta;
        b        = tb;
        ci       = tci;
        tbExpSum = es;
        tbExpOvf = eo;
        tbChkLat = lat;
        in_valid = 1'b1;
        for (int n = 0; n < 64 && !accepted; n++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept: got in_ready stuck low expected acceptance within 64 cycles");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sbq.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        logic [W+1:0] m;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           expPops;
        bit           seen;

        expPops = 0;
        #1;
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset sum", 64'(sum), 64'd0);
        checkOutput("reset ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("in_ready after release", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] directed vectors");
        applyStimulus(32'h0000_0005, 32'h0000_0003, 1'b0, 33'h0_0000_0008, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000, 1'b0, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 33'h0_2222_2222, 1'b0, 1'b0);
        expPops += 5;
        drain();

        $display("[TB] backpressure stream");
        fork
            begin : streamer
                for (int i = 0; i < 20; i++) begin
                    ra = $urandom();
                    rb = $urandom();
                    rc = 1'($urandom_range(0, 1));
                    m  = modelAdd(ra, rb, rc);
                    applyStimulus(ra, rb, rc, m[W:0], m[W+1], 1'b0);
                end
            end
            begin : readyCtl
                for (int c = 0; c < 20; c++) begin
                    out_ready = !(c >= 10 && c <= 15);
                    @(negedge clk);
                    if (c >= 10 && c <= 15) begin
                        checkOutput("in_ready while full", 64'(in_ready), 64'd0);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        expPops += 20;
        drain();

        $display("[TB] reset with operations in flight");
        out_ready = 1'b0;
        applyStimulus(32'd1,  32'd100, 1'b0, 33'd101, 1'b0, 1'b0);
        applyStimulus(32'd4,  32'd100, 1'b0, 33'd104, 1'b0, 1'b0);
        applyStimulus(32'd7,  32'd100, 1'b0, 33'd107, 1'b0, 1'b0);
        applyStimulus(32'd10, 32'd100, 1'b0, 33'd110, 1'b0, 1'b0);
        applyStimulus(32'd13, 32'd100, 1'b0, 33'd113, 1'b0, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = out_valid;
            @(posedge clk);
            #1;
        end
        checkOutput("stalled result present", 64'(seen), 64'd1);
        rst = 1'b1;
        sbq.delete();
        #1;
        checkOutput("reset mid-flight out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset mid-flight sum", 64'(sum), 64'd0);
        checkOutput("reset mid-flight ovf", 64'(ovf), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        checkOutput("in_ready after mid-flight reset", 64'(in_ready), 64'd1);
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            checkOutput("no stale result", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(32'h0000_00AA, 32'h0000_0055, 1'b1, 33'h0_0000_0100, 1'b0, 1'b1);
        expPops += 1;
        drain();

`ifdef ADD_SUB_EN
        $display("[TB] subtract path");
        sub = 1'b1;
        applyStimulus(32'd10, 32'd3, 1'b0, 33'h1_0000_0007, 1'b0, 1'b0);
        applyStimulus(32'd3, 32'd10, 1'b1, 33'h0_FFFF_FFF9, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'd1, 1'b0, 33'h1_7FFF_FFFF, 1'b1, 1'b0);
        sub = 1'b0;
        expPops += 3;
        drain();
`endif

        checkOutput("result count", 64'(popCount), 64'(expPops));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
